ddr_multi_reset_sequencer: RTL and testbench

DDR_MULTI_RESET_SEQUENCER -- requirements
Module: ddr_multi_reset_sequencer

---
 rtl/ddr_rst_seq_pkg.sv | 19 +
 rtl/ddr_rst_seq_sync.sv | 23 ++
 rtl/ddr_multi_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_ddr_multi_reset_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rst_seq_pkg.sv
// Shared state encoding and default parameter values for the DDR multi-channel reset sequencer.
package ddr_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RST  = 3'd1,
      ST_GAP  = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4,
      ST_FAIL = 3'd5
   } state_t;

   localparam int unsigned DEF_CHANNELS      = 2;
   localparam int unsigned DEF_PHASE_WIDTH   = 8;
   localparam int unsigned DEF_TIMEOUT_WIDTH = 16;
   localparam int unsigned DEF_MAX_RETRY     = 3;
   localparam int unsigned DEF_RETRY_WIDTH   = 4;

endpackage

// File: rtl/ddr_rst_seq_sync.sv
// Two-flop synchronizer bank for the per-channel DDR_CFG_DONE flags; clears to 0 on reset.
module ddr_rst_seq_sync #(
   parameter int unsigned pWidth = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [pWidth-1:0] d,
   output logic [pWidth-1:0] q
);

   logic [pWidth-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ddr_multi_reset_sequencer.sv
// Lockstep reset/start sequencer for pChannels DDR controllers: IDLE -> RST -> GAP -> RUN -> DONE/FAIL with retries.
// Define DDR_RST_SEQ_CDC_SYNC_EN to pass iddr_cfg_done through a 2-flop synchronizer before use.
module ddr_multi_reset_sequencer
   import ddr_rst_seq_pkg::*;
#(
   parameter int unsigned pChannels           = DEF_CHANNELS,
   parameter int unsigned pPhaseCntBitWidth   = DEF_PHASE_WIDTH,
   parameter int unsigned pTimeoutCntBitWidth = DEF_TIMEOUT_WIDTH,
   parameter int unsigned pMaxRetry           = DEF_MAX_RETRY,
   parameter int unsigned pRetryBitWidth      = DEF_RETRY_WIDTH
) (
   input  logic                      iCLK,
   input  logic                      iRST,
   input  logic                      iReq,
   input  logic [pChannels-1:0]      iddr_cfg_done,
   output logic [pChannels-1:0]      o_ddr_axi_rstn,
   output logic [pChannels-1:0]      o_ddr_cfg_seq_rst,
   output logic [pChannels-1:0]      o_ddr_cfg_seq_start,
   output logic                      o_ddr_init_done,
   output logic                      o_ddr_fail,
   output logic [pRetryBitWidth-1:0] oRetryCnt,
   output state_t                    dbg_state
);

   localparam logic [pRetryBitWidth-1:0] MAX_RETRY = pRetryBitWidth'(pMaxRetry);

   state_t                         state, next_state;
   logic [pPhaseCntBitWidth-1:0]   phase_cnt, phase_nxt;
   logic [pTimeoutCntBitWidth-1:0] to_cnt, to_nxt;
   logic [pRetryBitWidth-1:0]      retry_nxt;
   logic [pChannels-1:0]           cfg;
   logic [pChannels-1:0]           axi_nxt, seq_rst_nxt, start_nxt;
   logic                           init_nxt, fail_nxt;
   logic                           all_done, tracking;

`ifdef DDR_RST_SEQ_CDC_SYNC_EN
   ddr_rst_seq_sync #(
      .pWidth(pChannels)
   ) u_sync (
      .clk(iCLK),
      .rst(iRST),
      .d  (iddr_cfg_done),
      .q  (cfg)
   );
`else
   assign cfg = iddr_cfg_done;
`endif

   assign all_done  = &cfg;
   assign dbg_state = state;

   always_comb begin
      next_state  = state;
      phase_nxt   = '0;
      to_nxt      = '0;
      retry_nxt   = oRetryCnt;
      axi_nxt     = '0;
      seq_rst_nxt = '0;
      start_nxt   = '0;
      init_nxt    = 1'b0;
      fail_nxt    = 1'b0;
      tracking    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (&phase_cnt) next_state = ST_RST;
            else            phase_nxt  = phase_cnt + 1'b1;
         end
         ST_RST: begin
            if (&phase_cnt) next_state = ST_GAP;
            else            phase_nxt  = phase_cnt + 1'b1;
         end
         ST_GAP: begin
            if (&phase_cnt) next_state = ST_RUN;
            else            phase_nxt  = phase_cnt + 1'b1;
         end
         ST_RUN: begin
            // All-done wins over a coincident timeout, so no retry is spent.
            if (all_done) begin
               next_state = ST_DONE;
            end else if (&to_cnt) begin
               if (oRetryCnt < MAX_RETRY) begin
                  retry_nxt  = oRetryCnt + 1'b1;
                  next_state = ST_RST;
               end else begin
                  next_state = ST_FAIL;
               end
            end else begin
               to_nxt = to_cnt + 1'b1;
            end
         end
         ST_DONE, ST_FAIL: begin
            if (iReq) begin
               next_state = ST_IDLE;
               retry_nxt  = '0;
            end
         end
         default: next_state = ST_IDLE;
      endcase

      // Outputs are decoded from the state being entered so they line up with it.
      case (next_state)
         ST_IDLE, ST_RST: seq_rst_nxt = '1;
         ST_RUN, ST_DONE: start_nxt   = '1;
         ST_FAIL: begin
            seq_rst_nxt = '1;
            fail_nxt    = 1'b1;
         end
         default: ;
      endcase

      tracking = (state == ST_RUN || state == ST_DONE) &&
                 (next_state == ST_RUN || next_state == ST_DONE);
      if (tracking) axi_nxt = cfg;
      if (state == ST_DONE && next_state == ST_DONE) init_nxt = all_done;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state               <= ST_IDLE;
         phase_cnt           <= '0;
         to_cnt              <= '0;
         oRetryCnt           <= '0;
         o_ddr_axi_rstn      <= '0;
         o_ddr_cfg_seq_rst   <= '1;
         o_ddr_cfg_seq_start <= '0;
         o_ddr_init_done     <= 1'b0;
         o_ddr_fail          <= 1'b0;
      end else begin
         state               <= next_state;
         phase_cnt           <= phase_nxt;
         to_cnt              <= to_nxt;
         oRetryCnt           <= retry_nxt;
         o_ddr_axi_rstn      <= axi_nxt;
         o_ddr_cfg_seq_rst   <= seq_rst_nxt;
         o_ddr_cfg_seq_start <= start_nxt;
         o_ddr_init_done     <= init_nxt;
         o_ddr_fail          <= fail_nxt;
      end
   end

endmodule

// File: tb/tb_ddr_multi_reset_sequencer.sv
// Bench for ddr_multi_reset_sequencer: directed scenario steps plus random soak against a phase-countdown reference model.
module tb_ddr_multi_reset_sequencer;
   import ddr_rst_seq_pkg::*;

   localparam int CH   = 2;
   localparam int PW   = 4;
   localparam int TW   = 6;
   localparam int MAXR = 2;
   localparam int RW   = 4;
   localparam int PH   = 1 << PW;
   localparam int TO   = 1 << TW;

   localparam int M_IDLE = 0;
   localparam int M_RST  = 1;
   localparam int M_GAP  = 2;
   localparam int M_RUN  = 3;
   localparam int M_DONE = 4;
   localparam int M_FAIL = 5;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   logic req;
   logic [CH-1:0] cfg;
   logic [CH-1:0] axi_rstn, seq_rst, seq_start;
   logic init_done, fail;
   logic [RW-1:0] retry_cnt;
   state_t dbg_state;

   always #5 clk = ~clk;

   ddr_multi_reset_sequencer #(
      .pChannels          (CH),
      .pPhaseCntBitWidth  (PW),
      .pTimeoutCntBitWidth(TW),
      .pMaxRetry          (MAXR),
      .pRetryBitWidth     (RW)
   ) dut (
      .iCLK               (clk),
      .iRST               (rst),
      .iReq               (req),
      .iddr_cfg_done      (cfg),
      .o_ddr_axi_rstn     (axi_rstn),
      .o_ddr_cfg_seq_rst  (seq_rst),
      .o_ddr_cfg_seq_start(seq_start),
      .o_ddr_init_done    (init_done),
      .o_ddr_fail         (fail),
      .oRetryCnt          (retry_cnt),
      .dbg_state          (dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase name, cycles left in phase, attempts used
   int m_st, m_prev, m_left, m_tries;
   logic [CH-1:0] m_pipe0, m_pipe1;
   logic [CH-1:0] e_axi, e_seq_rst, e_start;
   logic e_done, e_fail;

   function automatic logic active(input int s);
      return (s == M_RUN) || (s == M_DONE);
   endfunction

   function automatic state_t to_state(input int s);
      case (s)
         M_IDLE:  return ST_IDLE;
         M_RST:   return ST_RST;
         M_GAP:   return ST_GAP;
         M_RUN:   return ST_RUN;
         M_DONE:  return ST_DONE;
         default: return ST_FAIL;
      endcase
   endfunction

   task automatic set_expected(input logic [CH-1:0] eff);
      e_seq_rst = (m_st == M_IDLE || m_st == M_RST || m_st == M_FAIL) ? '1 : '0;
      e_start   = active(m_st) ? '1 : '0;
      e_axi     = (active(m_prev) && active(m_st)) ? eff : '0;
      e_done    = (m_prev == M_DONE && m_st == M_DONE) ? (&eff) : 1'b0;
      e_fail    = (m_st == M_FAIL);
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_prev = M_IDLE; m_left = PH; m_tries = 0;
      m_pipe0 = '0; m_pipe1 = '0;
      set_expected('0);
   endtask

   task automatic model_step(input logic [CH-1:0] c, input logic r);
      logic [CH-1:0] eff;
`ifdef DDR_RST_SEQ_CDC_SYNC_EN
      eff = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = c;
`else
      eff = c;
`endif
      m_prev = m_st;
      case (m_st)
         M_IDLE, M_RST, M_GAP: begin
            m_left--;
            if (m_left == 0) begin
               m_st   = m_st + 1;
               m_left = (m_st == M_RUN) ? TO : PH;
            end
         end
         M_RUN: begin
            if (&eff) m_st = M_DONE;
            else begin
               m_left--;
               if (m_left == 0) begin
                  if (m_tries < MAXR) begin
                     m_tries++; m_st = M_RST; m_left = PH;
                  end else m_st = M_FAIL;
               end
            end
         end
         default: if (r) begin
            m_st = M_IDLE; m_left = PH; m_tries = 0;
         end
      endcase
      set_expected(eff);
   endtask

   // scoreboard
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("axi_rstn",  32'(axi_rstn),  32'(e_axi));
      check("seq_rst",   32'(seq_rst),   32'(e_seq_rst));
      check("seq_start", 32'(seq_start), 32'(e_start));
      check("init_done", 32'(init_done), 32'(e_done));
      check("fail",      32'(fail),      32'(e_fail));
      check("retry_cnt", 32'(retry_cnt), 32'(m_tries));
      check("state",     32'(dbg_state), 32'(to_state(m_st)));
   endtask

   // driver: called at a negedge, returns at the next negedge
   task automatic cycle(input logic [CH-1:0] c, input logic r);
      cfg = c; req = r;
      @(posedge clk);
      model_step(c, r);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   function automatic logic [CH-1:0] rand_partial();
      return CH'($urandom_range(0, (1 << CH) - 2));
   endfunction

   task automatic wait_state(input int target, input int budget, input logic rnd, input logic [CH-1:0] fixed);
      int n = 0;
      while (m_st != target && n < budget) begin
         if (rnd) cycle(rand_partial(), ($urandom_range(0, 7) == 0) && !(m_st == M_DONE || m_st == M_FAIL));
         else     cycle(fixed, 1'b0);
         n++;
      end
      if (m_st != target) begin
         vectors++; miscompares++;
         $error("FAIL wait_state target=%0d observed_model=%0d budget=%0d", target, m_st, budget);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH-1:0] c;
      rst = 1'b1; req = 1'b0; cfg = '0;
      model_reset();
      #2;
      check_outputs();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // power-up sequence, all channels done 5 cycles into RUN
      wait_state(M_RUN, 200, 1'b1, '0);
      repeat (5) cycle(rand_partial(), 1'b0);
      repeat (4) cycle('1, 1'b0);

      // channel 1 drops for 3 cycles while DONE
      repeat (3) cycle(2'b01, 1'b0);
      repeat (3) cycle('1, 1'b0);

      // re-init, then channel 1 never completes: retries then FAIL; iReq in RST ignored
      cycle('1, 1'b1);
      wait_state(M_RST, 100, 1'b0, 2'b01);
      cycle(2'b01, 1'b1);
      wait_state(M_FAIL, 1000, 1'b0, 2'b01);
      repeat (5) cycle(2'b01, 1'b0);

      // leave FAIL; all done exactly on the timeout cycle
      cycle(2'b01, 1'b1);
      wait_state(M_RUN, 200, 1'b1, '0);
      while (m_left > 1) cycle(rand_partial(), 1'b0);
      cycle('1, 1'b0);
      repeat (3) cycle('1, 1'b0);

      // asynchronous reset in the middle of GAP
      cycle('1, 1'b1);
      wait_state(M_GAP, 200, 1'b1, '0);
      repeat (5) cycle(rand_partial(), 1'b0);
      #2 rst = 1'b1;
      model_reset();
      #1 check_outputs();
      @(posedge clk); #1 check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // random soak
      repeat (1500) begin
         c = ($urandom_range(0, 3) == 0) ? '1 : CH'($urandom());
         cycle(c, $urandom_range(0, 15) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
